// File: rtl/chunk_cache_set.sv
// rtl/chunk_cache_set.sv - multi-line LRU chunk cache with data/fetch ports and fill/evict handshake
//
// Ports:
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   address, mask, read_trigger, write_trigger, write_value
//                            data port: byte address, byte enables, access strobes, write data
//   read_value, contains_address
//                            data port word (0 on miss) and hit flag, combinational
//   command_address, read_command, contains_command_address
//                            instruction fetch port, combinational
//   fill_valid, fill_address, fill_data, fill_ready
//                            line fill request from the memory controller, fill_ready pulses on install
//   evict_valid, evict_address, evict_data, evict_ready
//                            dirty victim write-back request to the memory controller
//   busy                     an eviction or fill is in progress
module chunk_cache_set #(
    parameter int LINE_COUNT     = 4,
    parameter int WORDS_PER_LINE = 4,
    parameter int DATA_SIZE      = 32,
    parameter int ADDRESS_SIZE   = 28,
    localparam int MASK_SIZE     = DATA_SIZE / 8,
    localparam int LINE_BITS     = DATA_SIZE * WORDS_PER_LINE
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDRESS_SIZE-1:0] address,
    input  logic [MASK_SIZE-1:0]    mask,
    input  logic                    read_trigger,
    input  logic                    write_trigger,
    input  logic [DATA_SIZE-1:0]    write_value,
    output logic [DATA_SIZE-1:0]    read_value,
    output logic                    contains_address,
    input  logic [ADDRESS_SIZE-1:0] command_address,
    output logic [DATA_SIZE-1:0]    read_command,
    output logic                    contains_command_address,
    input  logic                    fill_valid,
    input  logic [ADDRESS_SIZE-1:0] fill_address,
    input  logic [LINE_BITS-1:0]    fill_data,
    output logic                    fill_ready,
    output logic                    evict_valid,
    output logic [ADDRESS_SIZE-1:0] evict_address,
    output logic [LINE_BITS-1:0]    evict_data,
    input  logic                    evict_ready,
    output logic                    busy
);

    localparam int MB    = $clog2(MASK_SIZE);
    localparam int WB    = $clog2(WORDS_PER_LINE);
    localparam int OFF   = MB + WB;
    localparam int TAG_W = ADDRESS_SIZE - OFF;
    localparam int LW    = $clog2(LINE_COUNT);

    typedef enum logic [1:0] {S_IDLE, S_EVICT, S_FILL} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          victim_q, victim_d;
    logic [LINE_COUNT-1:0]  valid_q, valid_d;
    logic [LINE_COUNT-1:0]  dirty_q, dirty_d;
    logic [TAG_W-1:0]       tag_q  [LINE_COUNT];
    logic [TAG_W-1:0]       tag_d  [LINE_COUNT];
    logic [LINE_BITS-1:0]   data_q [LINE_COUNT];
    logic [LINE_BITS-1:0]   data_d [LINE_COUNT];
    logic [15:0]            age_q  [LINE_COUNT];
    logic [15:0]            age_d  [LINE_COUNT];

    logic [TAG_W-1:0]       data_tag, cmd_tag, fill_tag;
    logic [WB-1:0]          data_word, cmd_word;
    logic [LINE_COUNT-1:0]  data_hit, cmd_hit, blocked;
    logic                   fill_resident;
    logic [LW-1:0]          victim_sel;
    logic                   found_invalid;
    logic [15:0]            best_age;
    logic                   install;
    logic [LW-1:0]          install_idx;
    logic                   unused_bits;

    assign data_tag    = address[ADDRESS_SIZE-1:OFF];
    assign cmd_tag     = command_address[ADDRESS_SIZE-1:OFF];
    assign fill_tag    = fill_address[ADDRESS_SIZE-1:OFF];
    assign data_word   = address[OFF-1:MB];
    assign cmd_word    = command_address[OFF-1:MB];
    assign unused_bits = ^{fill_address[OFF-1:0], address[MB-1:0], command_address[MB-1:0]};

    // Lookup on both ports; the line being evicted/refilled is hidden from them.
    always_comb begin
        busy          = (state_q != S_IDLE);
        data_hit      = '0;
        cmd_hit       = '0;
        blocked       = '0;
        fill_resident = 1'b0;
        read_value    = '0;
        read_command  = '0;
        for (int i = 0; i < LINE_COUNT; i++) begin
            blocked[i]  = busy && (victim_q == LW'(i));
            data_hit[i] = valid_q[i] && (tag_q[i] == data_tag) && !blocked[i];
            cmd_hit[i]  = valid_q[i] && (tag_q[i] == cmd_tag) && !blocked[i];
            if (data_hit[i]) read_value = data_q[i][int'(data_word)*DATA_SIZE +: DATA_SIZE];
            if (cmd_hit[i]) read_command = data_q[i][int'(cmd_word)*DATA_SIZE +: DATA_SIZE];
            if (valid_q[i] && (tag_q[i] == fill_tag)) fill_resident = 1'b1;
        end
        contains_address         = |data_hit;
        contains_command_address = |cmd_hit;
    end

    // Victim: lowest invalid line first; otherwise oldest, strict compare keeps ties at the lowest index.
    always_comb begin
        victim_sel    = '0;
        found_invalid = 1'b0;
        best_age      = age_q[0];
        for (int i = 0; i < LINE_COUNT; i++) begin
            if (!valid_q[i] && !found_invalid) begin
                victim_sel    = LW'(i);
                found_invalid = 1'b1;
            end
        end
        if (!found_invalid) begin
            for (int i = 1; i < LINE_COUNT; i++) begin
                if (age_q[i] > best_age) begin
                    best_age   = age_q[i];
                    victim_sel = LW'(i);
                end
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        fill_ready    = 1'b0;
        evict_valid   = 1'b0;
        evict_address = '0;
        evict_data    = '0;
        install       = 1'b0;
        install_idx   = victim_q;
        case (state_q)
            S_IDLE: begin
                if (fill_valid) begin
                    if (fill_resident) begin
                        // Resident copy may hold newer writes; acknowledge and drop the fill.
                        fill_ready = 1'b1;
                    end else if (!valid_q[victim_sel] || !dirty_q[victim_sel]) begin
                        install     = 1'b1;
                        install_idx = victim_sel;
                        fill_ready  = 1'b1;
                    end else begin
                        victim_d = victim_sel;
                        state_d  = S_EVICT;
                    end
                end
            end
            S_EVICT: begin
                evict_valid   = 1'b1;
                evict_address = {tag_q[victim_q], {OFF{1'b0}}};
                evict_data    = data_q[victim_q];
                if (evict_ready) state_d = S_FILL;
            end
            S_FILL: begin
                install    = 1'b1;
                fill_ready = 1'b1;
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        data_d  = data_q;
        age_d   = age_q;
        for (int i = 0; i < LINE_COUNT; i++) begin
            if (write_trigger && data_hit[i]) begin
                for (int b = 0; b < MASK_SIZE; b++) begin
                    if (mask[b]) data_d[i][int'(data_word)*DATA_SIZE + b*8 +: 8] = write_value[b*8 +: 8];
                end
                dirty_d[i] = 1'b1;
            end
            if (install && (install_idx == LW'(i))) begin
                valid_d[i] = 1'b1;
                dirty_d[i] = 1'b0;
                tag_d[i]   = fill_tag;
                data_d[i]  = fill_data;
                age_d[i]   = 16'h0000;
            end else if ((data_hit[i] && (read_trigger || write_trigger)) || cmd_hit[i]) begin
                age_d[i] = 16'h0000;
            end else if (valid_q[i]) begin
                age_d[i] = (age_q[i] == 16'hFFFF) ? age_q[i] : age_q[i] + 16'd1;
            end else begin
                age_d[i] = 16'hFFFF;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            valid_q  <= '0;
            dirty_q  <= '0;
            for (int i = 0; i < LINE_COUNT; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
                age_q[i]  <= 16'hFFFF;
            end
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            valid_q  <= valid_d;
            dirty_q  <= dirty_d;
            for (int i = 0; i < LINE_COUNT; i++) begin
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
                age_q[i]  <= age_d[i];
            end
        end
    end

endmodule

// File: tb/tb_chunk_cache_set.sv
// tb/tb_chunk_cache_set.sv - self-checking bench for chunk_cache_set
module tb_chunk_cache_set;
    localparam int AS = 28;
    localparam int DS = 32;
    localparam int LB = 128;
    localparam logic [AS-1:0] PARK = 28'hFFFFFF0;

    logic          clk = 1'b0;
    logic          reset;
    logic [AS-1:0] address;
    logic [3:0]    mask;
    logic          read_trigger, write_trigger;
    logic [DS-1:0] write_value, read_value, read_command;
    logic          contains_address, contains_command_address;
    logic [AS-1:0] command_address, fill_address, evict_address;
    logic [LB-1:0] fill_data, evict_data;
    logic          fill_valid, fill_ready, evict_valid, evict_ready, busy;

    chunk_cache_set dut (
        .clk(clk), .reset(reset), .address(address), .mask(mask),
        .read_trigger(read_trigger), .write_trigger(write_trigger),
        .write_value(write_value), .read_value(read_value),
        .contains_address(contains_address), .command_address(command_address),
        .read_command(read_command), .contains_command_address(contains_command_address),
        .fill_valid(fill_valid), .fill_address(fill_address), .fill_data(fill_data),
        .fill_ready(fill_ready), .evict_valid(evict_valid), .evict_address(evict_address),
        .evict_data(evict_data), .evict_ready(evict_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [LB-1:0] exp;
    } sb_t;

    typedef struct {
        logic          fetch;
        logic [AS-1:0] addr;
        logic [DS-1:0] val;
        logic          hit;
    } probe_t;

    sb_t    sb_q[$];
    probe_t probes[16];
    int     checks = 0;
    int     errors = 0;

    function automatic logic [LB-1:0] line_of(input logic [31:0] b);
        return {b + 32'd3, b + 32'd2, b + 32'd1, b};
    endfunction

    task automatic push(input string n, input logic [LB-1:0] e);
        sb_t s;
        s.name = n;
        s.exp  = e;
        sb_q.push_back(s);
    endtask

    task automatic pop_cmp(input logic [LB-1:0] act);
        sb_t s;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty actual=%0h", act);
        end else begin
            s = sb_q.pop_front();
            if (act !== s.exp) begin
                errors++;
                $display("FAIL %s actual=%0h required=%0h", s.name, act, s.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_now(input logic [AS-1:0] a, input logic [LB-1:0] d, input string n);
        fill_valid = 1'b1; fill_address = a; fill_data = d;
        push({n, "_fill_ready"}, 1); push({n, "_evict_valid"}, 0);
        @(negedge clk);
        pop_cmp(fill_ready); pop_cmp(evict_valid);
        step();
        fill_valid = 1'b0;
    endtask

    task automatic read_chk(input logic [AS-1:0] a, input logic [DS-1:0] v, input logic h, input string n);
        address = a;
        push({n, "_hit"}, h); push({n, "_value"}, v);
        @(negedge clk);
        pop_cmp(contains_address); pop_cmp(read_value);
        step();
    endtask

    task automatic touch(input logic [AS-1:0] a);
        address = a; read_trigger = 1'b1;
        step();
        read_trigger = 1'b0;
    endtask

    task automatic write_word(input logic [AS-1:0] a, input logic [DS-1:0] v, input logic [3:0] m);
        address = a; write_value = v; mask = m; write_trigger = 1'b1;
        step();
        write_trigger = 1'b0;
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (probes[i].fetch) begin
                command_address = probes[i].addr;
                push($sformatf("row%0d_fetch_hit", i), probes[i].hit);
                push($sformatf("row%0d_fetch_value", i), probes[i].val);
                @(negedge clk);
                pop_cmp(contains_command_address); pop_cmp(read_command);
            end else begin
                address = probes[i].addr;
                push($sformatf("row%0d_read_hit", i), probes[i].hit);
                push($sformatf("row%0d_read_value", i), probes[i].val);
                @(negedge clk);
                pop_cmp(contains_address); pop_cmp(read_value);
            end
            step();
            command_address = PARK;
        end
    endtask

    initial begin
        probes[0]  = '{1'b0, 28'h0000108, 32'd3, 1'b1};
        probes[1]  = '{1'b1, 28'h0000104, 32'd2, 1'b1};
        probes[2]  = '{1'b0, 28'h000010C, 32'd4, 1'b1};
        probes[3]  = '{1'b1, 28'h000010C, 32'd4, 1'b1};
        probes[4]  = '{1'b0, 28'h0000200, 32'd0, 1'b0};
        probes[5]  = '{1'b1, 28'h0000300, 32'd0, 1'b0};
        probes[6]  = '{1'b0, 28'h0000100, 32'd1, 1'b1};
        probes[7]  = '{1'b0, 28'h0000500, 32'd0, 1'b0};
        probes[8]  = '{1'b0, 28'h0000600, 32'h600, 1'b1};
        probes[9]  = '{1'b0, 28'h0000204, 32'h201, 1'b1};
        probes[10] = '{1'b0, 28'h000030C, 32'h303, 1'b1};
        probes[11] = '{1'b1, 28'h0000404, 32'h401, 1'b1};
        probes[12] = '{1'b0, 28'h0000800, 32'd0, 1'b0};
        probes[13] = '{1'b0, 28'h0000904, 32'h901, 1'b1};
        probes[14] = '{1'b1, 28'h0000C08, 32'hC02, 1'b1};
        probes[15] = '{1'b1, 28'h0000A0C, 32'hA03, 1'b1};

        reset = 1'b1; address = '0; mask = '0; read_trigger = 1'b0; write_trigger = 1'b0;
        write_value = '0; command_address = PARK; fill_valid = 1'b0; fill_address = '0;
        fill_data = '0; evict_ready = 1'b0;

        // Reset state
        @(negedge clk);
        push("rst_busy", 0); push("rst_fill_ready", 0); push("rst_evict_valid", 0);
        push("rst_contains", 0); push("rst_read_value", 0); push("rst_contains_cmd", 0);
        pop_cmp(busy); pop_cmp(fill_ready); pop_cmp(evict_valid);
        pop_cmp(contains_address); pop_cmp(read_value); pop_cmp(contains_command_address);
        step();
        reset = 1'b0;
        step();

        // First fill, probes, masked write, resident refill
        fill_now(28'h0000100, line_of(32'd1), "fill100");
        run_rows(0, 6);
        write_word(28'h0000100, 32'hAABBCCDD, 4'b0101);
        read_chk(28'h0000100, 32'h00BB00DD, 1'b1, "merged");
        fill_now(28'h0000100, line_of(32'h55), "refill100");
        read_chk(28'h0000100, 32'h00BB00DD, 1'b1, "retained");

        // Dirty LRU victim eviction
        fill_now(28'h0000200, line_of(32'h200), "fill200");
        fill_now(28'h0000300, line_of(32'h300), "fill300");
        fill_now(28'h0000400, line_of(32'h400), "fill400");
        touch(28'h0000200); touch(28'h0000300); touch(28'h0000400);
        fill_valid = 1'b1; fill_address = 28'h0000500; fill_data = line_of(32'h500);
        push("ev_req_fill_ready", 0); push("ev_req_evict_valid", 0);
        @(negedge clk);
        pop_cmp(fill_ready); pop_cmp(evict_valid);
        step();
        for (int c = 0; c < 5; c++) begin
            address = 28'h0000100;
            push("ev_hold_valid", 1); push("ev_hold_addr", 28'h0000100);
            push("ev_hold_data", {32'd4, 32'd3, 32'd2, 32'h00BB00DD});
            push("ev_hold_fill_ready", 0); push("ev_hold_busy", 1);
            push("ev_victim_hit", 0); push("ev_victim_value", 0);
            @(negedge clk);
            pop_cmp(evict_valid); pop_cmp(evict_address); pop_cmp(evict_data);
            pop_cmp(fill_ready); pop_cmp(busy); pop_cmp(contains_address); pop_cmp(read_value);
            step();
        end
        read_chk(28'h0000208, 32'h202, 1'b1, "ev_other_line");
        evict_ready = 1'b1;
        push("ev_ack_valid", 1); push("ev_ack_fill_ready", 0);
        @(negedge clk);
        pop_cmp(evict_valid); pop_cmp(fill_ready);
        step();
        evict_ready = 1'b0;
        push("fill_state_ready", 1); push("fill_state_evict", 0); push("fill_state_busy", 1);
        @(negedge clk);
        pop_cmp(fill_ready); pop_cmp(evict_valid); pop_cmp(busy);
        step();
        fill_valid = 1'b0;
        push("post_fill_busy", 0);
        @(negedge clk);
        pop_cmp(busy);
        read_chk(28'h0000508, 32'h502, 1'b1, "new_line");
        read_chk(28'h0000100, 32'd0, 1'b0, "evicted_line");

        // Clean LRU replacement: line holding 0x500 is oldest
        touch(28'h0000200); touch(28'h0000300); touch(28'h0000400);
        fill_now(28'h0000600, line_of(32'h600), "clean_fill");
        push("clean_busy", 0); push("clean_evict_valid", 0);
        @(negedge clk);
        pop_cmp(busy); pop_cmp(evict_valid);
        step();
        run_rows(7, 11);

        // Reset in the middle of an eviction
        write_word(28'h0000600, 32'h1, 4'hF);
        write_word(28'h0000200, 32'h2, 4'hF);
        write_word(28'h0000300, 32'h3, 4'hF);
        write_word(28'h0000400, 32'h4, 4'hF);
        fill_valid = 1'b1; fill_address = 28'h0000700; fill_data = line_of(32'h700);
        step();
        push("rst_ev_valid_before", 1); push("rst_ev_addr_before", 28'h0000600);
        @(negedge clk);
        pop_cmp(evict_valid); pop_cmp(evict_address);
        step();
        #2;
        reset = 1'b1; fill_valid = 1'b0; address = 28'h0000200; command_address = 28'h0000300;
        #1;
        push("mid_rst_evict_valid", 0); push("mid_rst_busy", 0); push("mid_rst_fill_ready", 0);
        push("mid_rst_contains", 0); push("mid_rst_read_value", 0); push("mid_rst_contains_cmd", 0);
        pop_cmp(evict_valid); pop_cmp(busy); pop_cmp(fill_ready);
        pop_cmp(contains_address); pop_cmp(read_value); pop_cmp(contains_command_address);
        @(negedge clk);
        reset = 1'b0; command_address = PARK;
        step();
        fill_now(28'h0000800, line_of(32'h800), "after_rst_800");
        read_chk(28'h0000804, 32'h801, 1'b1, "after_rst_read");
        fill_now(28'h0000900, line_of(32'h900), "fill900");
        fill_now(28'h0000A00, line_of(32'hA00), "fillA00");
        fill_now(28'h0000B00, line_of(32'hB00), "fillB00");
        fill_now(28'h0000C00, line_of(32'hC00), "fillC00");
        run_rows(12, 15);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
